// File: rtl/gravsim_avm_pkg.sv
// rtl/gravsim_avm_pkg.sv - shared types and register map for the gravsim Avalon-MM sequencer master
// Contents: avm_state_t FSM encoding, word offsets of the gravsim slave register file, MAX_BODIES.
package gravsim_avm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_DRAIN,
        ST_WR_FETCH,
        ST_WR_REQ,
        ST_FINISH
    } avm_state_t;

    localparam int unsigned MAX_BODIES = 10;

    // Scalar control words
    localparam int unsigned REG_G     = 0;
    localparam int unsigned REG_NUM   = 1;
    localparam int unsigned REG_START = 2;
    localparam int unsigned REG_DONE  = 3;

    // Per-body arrays, MAX_BODIES words each, packed after the control words
    localparam int unsigned MASS_BASE  = 4;
    localparam int unsigned RAD_BASE   = MASS_BASE  + MAX_BODIES;
    localparam int unsigned POS_X_BASE = RAD_BASE   + MAX_BODIES;
    localparam int unsigned POS_Y_BASE = POS_X_BASE + MAX_BODIES;
    localparam int unsigned POS_Z_BASE = POS_Y_BASE + MAX_BODIES;
    localparam int unsigned VEL_X_BASE = POS_Z_BASE + MAX_BODIES;
    localparam int unsigned VEL_Y_BASE = VEL_X_BASE + MAX_BODIES;
    localparam int unsigned VEL_Z_BASE = VEL_Y_BASE + MAX_BODIES;
    localparam int unsigned ACC_X_BASE = VEL_Z_BASE + MAX_BODIES;
    localparam int unsigned ACC_Y_BASE = ACC_X_BASE + MAX_BODIES;
    localparam int unsigned ACC_Z_BASE = ACC_Y_BASE + MAX_BODIES;

endpackage

// File: rtl/avalon_mm_seq_master_if.sv
// rtl/avalon_mm_seq_master_if.sv - command, stream and Avalon-MM signals of the sequencer master
// Groups: cmd_* block request/status, wr_* write stream in, rd_* read stream out, avm_* Avalon-MM bus.
// master modport is the sequencer master's view; slave modport is the view of whatever surrounds it.
interface avalon_mm_seq_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
);
    logic                  cmd_start;
    logic                  cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [CNT_W-1:0]      cmd_count;
    logic                  cmd_busy;
    logic                  cmd_done;
    logic [DATA_W-1:0]     wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_valid;
    logic                  avm_cs;
    logic                  avm_read;
    logic                  avm_write;
    logic [DATA_W/8-1:0]   avm_byte_en;
    logic [ADDR_W-1:0]     avm_addr;
    logic [DATA_W-1:0]     avm_writedata;
    logic [DATA_W-1:0]     avm_readdata;
    logic                  avm_waitrequest;

    modport master (
        input  cmd_start, cmd_write, cmd_addr, cmd_count, wr_data, wr_valid,
               avm_readdata, avm_waitrequest,
        output cmd_busy, cmd_done, wr_ready, rd_data, rd_valid,
               avm_cs, avm_read, avm_write, avm_byte_en, avm_addr, avm_writedata
    );

    modport slave (
        output cmd_start, cmd_write, cmd_addr, cmd_count, wr_data, wr_valid,
               avm_readdata, avm_waitrequest,
        input  cmd_busy, cmd_done, wr_ready, rd_data, rd_valid,
               avm_cs, avm_read, avm_write, avm_byte_en, avm_addr, avm_writedata
    );
endinterface

// File: rtl/avm_rd_latency_pipe.sv
// rtl/avm_rd_latency_pipe.sv - tags accepted reads through the fixed slave read latency
// Ports: clk_i, rst_i (async, active high); accept_i read accepted this cycle;
//        strobe_o sample avm_readdata this cycle; valid_o registered copy of strobe_o (read stream valid).
module avm_rd_latency_pipe #(
    parameter int LATENCY = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic accept_i,
    output logic strobe_o,
    output logic valid_o
);
    // Stage k of tags is an acceptance k cycles old. Stage LATENCY is the capture
    // cycle; one extra stage gives the registered valid, so even LATENCY = 0 is uniform.
    logic [LATENCY+1:1] tag_q;
    logic [LATENCY+1:0] tags;

    assign tags     = {tag_q, accept_i};
    assign strobe_o = tags[LATENCY];
    assign valid_o  = tags[LATENCY+1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_q <= '0;
        end else begin
            tag_q <= tags[LATENCY:0];
        end
    end
endmodule

// File: rtl/avalon_mm_seq_master.sv
// rtl/avalon_mm_seq_master.sv - Avalon-MM master running one read or write block of COUNT words
// Ports: clk_i, rst_i (async, active high); bus (master modport): cmd_* block command and status,
//        wr_* write data stream (valid/ready), rd_* read data stream (valid only), avm_* Avalon-MM master.
module avalon_mm_seq_master
    import gravsim_avm_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int CNT_W        = 8,
    parameter int READ_LATENCY = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    avalon_mm_seq_master_if.master  bus
);
    avm_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    rem_q, rem_d;      // words still to issue on the bus
    logic [CNT_W-1:0]    cap_q, cap_d;      // read words captured so far
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_req, wr_req, accepted, cap_stb, rd_valid;

    assign rd_req   = (state_q == ST_RD_REQ);
    assign wr_req   = (state_q == ST_WR_REQ);
    assign accepted = (rd_req | wr_req) & ~bus.avm_waitrequest;

    avm_rd_latency_pipe #(.LATENCY(READ_LATENCY)) u_rd_pipe (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .accept_i (rd_req & ~bus.avm_waitrequest),
        .strobe_o (cap_stb),
        .valid_o  (rd_valid)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        rem_d   = rem_q;
        wdata_d = wdata_q;
        cap_d   = cap_q + CNT_W'(cap_stb);
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_start) begin
                    addr_d  = bus.cmd_addr;
                    count_d = bus.cmd_count;
                    rem_d   = bus.cmd_count;
                    cap_d   = '0;
                    if (bus.cmd_count == '0)  state_d = ST_FINISH;
                    else if (bus.cmd_write)   state_d = ST_WR_FETCH;
                    else                      state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (accepted) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) state_d = ST_RD_DRAIN;
                end
            end
            ST_RD_DRAIN: begin
                if (cap_q == count_q) state_d = ST_FINISH;
            end
            ST_WR_FETCH: begin
                if (bus.wr_valid) begin
                    wdata_d = bus.wr_data;
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                if (accepted) begin
                    addr_d  = addr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == CNT_W'(1)) ? ST_FINISH : ST_WR_FETCH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            count_q   <= '0;
            rem_q     <= '0;
            cap_q     <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            cap_q   <= cap_d;
            wdata_q <= wdata_d;
            if (cap_stb) rd_data_q <= bus.avm_readdata;
        end
    end

    // Request outputs are decoded from state only, so they stay stable while stalled.
    assign bus.cmd_busy      = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign bus.cmd_done      = (state_q == ST_FINISH);
    assign bus.wr_ready      = (state_q == ST_WR_FETCH);
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_valid      = rd_valid;
    assign bus.avm_read      = rd_req;
    assign bus.avm_write     = wr_req;
    assign bus.avm_cs        = rd_req | wr_req;
    assign bus.avm_byte_en   = (rd_req | wr_req) ? '1 : '0;
    assign bus.avm_addr      = (rd_req | wr_req) ? addr_q : '0;
    assign bus.avm_writedata = wr_req ? wdata_q : '0;
endmodule

// File: tb/tb_avalon_mm_seq_master.sv
// tb/tb_avalon_mm_seq_master.sv - scoreboard bench for avalon_mm_seq_master at read latency 0 and 2
module tb_avalon_mm_seq_master;
    import gravsim_avm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] exp_rd_q[$];
    logic [39:0] exp_wr_q[$];
    logic [7:0]  exp_ad_q[$];

    avalon_mm_seq_master_if #(.ADDR_W(8), .DATA_W(32), .CNT_W(8)) b0 ();
    avalon_mm_seq_master_if #(.ADDR_W(8), .DATA_W(32), .CNT_W(8)) b2 ();

    avalon_mm_seq_master #(.READ_LATENCY(0)) u_dut0 (.clk_i(clk), .rst_i(rst), .bus(b0.master));
    avalon_mm_seq_master #(.READ_LATENCY(2)) u_dut2 (.clk_i(clk), .rst_i(rst), .bus(b2.master));

    // Slave models: read data = word address + 100. b0 answers combinationally,
    // b2 answers two cycles after acceptance and shows garbage otherwise.
    logic       s_v1 = 1'b0, s_v2 = 1'b0;
    logic [7:0] s_a1 = '0, s_a2 = '0;
    always @(posedge clk) begin
        s_v1 <= b2.avm_read & ~b2.avm_waitrequest;
        s_a1 <= b2.avm_addr;
        s_v2 <= s_v1;
        s_a2 <= s_a1;
    end
    assign b0.avm_readdata = b0.avm_read ? 32'(b0.avm_addr) + 32'd100 : 32'hDEAD_BEEF;
    assign b2.avm_readdata = s_v2 ? 32'(s_a2) + 32'd100 : 32'hDEAD_BEEF;

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if ({b0.cmd_busy, b0.cmd_done, b0.wr_ready, b0.rd_data, b0.rd_valid, b0.avm_cs, b0.avm_read,
             b0.avm_write, b0.avm_byte_en, b0.avm_addr, b0.avm_writedata} !== '0)
            $display("FAIL reset_outputs_lat0: some output nonzero in reset, required all 0");
        else n_pass++;
        n_chk++;
        if ({b2.cmd_busy, b2.cmd_done, b2.wr_ready, b2.rd_data, b2.rd_valid, b2.avm_cs, b2.avm_read,
             b2.avm_write, b2.avm_byte_en, b2.avm_addr, b2.avm_writedata} !== '0)
            $display("FAIL reset_outputs_lat2: some output nonzero in reset, required all 0");
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read_zero_wait();
        int rd_cnt, busy_cnt, done_cnt, first_rd, last_rd;
        logic [7:0]  exp_addr;
        logic [31:0] exp;
        rd_cnt = 0; busy_cnt = 0; done_cnt = 0; first_rd = -1; last_rd = -1; exp_addr = 8'd23;
        for (int k = 0; k < 4; k++) exp_rd_q.push_back(32'd123 + 32'(k));
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            b0.cmd_start = (i == 0); b0.cmd_write = 1'b0; b0.cmd_addr = 8'd23; b0.cmd_count = 8'd4;
            #1;
            if (b0.avm_read) begin
                if (first_rd < 0) first_rd = i;
                last_rd = i; rd_cnt++;
                n_chk++;
                if (b0.avm_addr !== exp_addr) $display("FAIL t1_addr: got %0d required %0d", b0.avm_addr, exp_addr);
                else n_pass++;
                exp_addr++;
            end
            if (b0.rd_valid) begin
                n_chk++;
                if (exp_rd_q.size() == 0) $display("FAIL t1_extra_rd: got data %0d, none expected", b0.rd_data);
                else begin
                    exp = exp_rd_q.pop_front();
                    if (b0.rd_data !== exp) $display("FAIL t1_rd_data: got %0d required %0d", b0.rd_data, exp);
                    else n_pass++;
                end
            end
            busy_cnt += int'(b0.cmd_busy);
            done_cnt += int'(b0.cmd_done);
        end
        n_chk++; if (rd_cnt !== 4)   $display("FAIL t1_read_cycles: got %0d required 4", rd_cnt);   else n_pass++;
        n_chk++; if (first_rd !== 1) $display("FAIL t1_first_read: got %0d required 1", first_rd);  else n_pass++;
        n_chk++; if (last_rd !== 4)  $display("FAIL t1_last_read: got %0d required 4", last_rd);    else n_pass++;
        n_chk++; if (busy_cnt !== 5) $display("FAIL t1_busy_cycles: got %0d required 5", busy_cnt); else n_pass++;
        n_chk++; if (done_cnt !== 1) $display("FAIL t1_done_pulses: got %0d required 1", done_cnt); else n_pass++;
        n_chk++; if (exp_rd_q.size() !== 0) $display("FAIL t1_missing_rd: %0d words left, required 0", exp_rd_q.size()); else n_pass++;
    endtask

    task automatic test_read_stall();
        int rd_cyc, rv_cnt, done_cnt, acc_at;
        int acc_q[$];
        logic [7:0]  exp_addr;
        logic [31:0] exp;
        rd_cyc = 0; rv_cnt = 0; done_cnt = 0; exp_addr = 8'd40;
        for (int k = 0; k < 4; k++) exp_rd_q.push_back(32'd140 + 32'(k));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            b2.cmd_start = (i == 0); b2.cmd_write = 1'b0; b2.cmd_addr = 8'd40; b2.cmd_count = 8'd4;
            b2.avm_waitrequest = (i == 2 || i == 3);
            #1;
            if (b2.avm_read) begin
                rd_cyc++;
                n_chk++;
                if (b2.avm_addr !== exp_addr) $display("FAIL t2_addr: got %0d required %0d", b2.avm_addr, exp_addr);
                else n_pass++;
                if (!b2.avm_waitrequest) begin
                    acc_q.push_back(i);
                    exp_addr++;
                end
            end
            if (b2.rd_valid) begin
                rv_cnt++;
                n_chk++;
                if (exp_rd_q.size() == 0 || acc_q.size() == 0)
                    $display("FAIL t2_extra_rd: got data %0d, none expected", b2.rd_data);
                else begin
                    exp = exp_rd_q.pop_front();
                    acc_at = acc_q.pop_front();
                    if (b2.rd_data !== exp || i != acc_at + 3)
                        $display("FAIL t2_rd: got %0d at cycle %0d required %0d at cycle %0d", b2.rd_data, i, exp, acc_at + 3);
                    else n_pass++;
                end
            end
            done_cnt += int'(b2.cmd_done);
        end
        b2.avm_waitrequest = 1'b0;
        n_chk++; if (rd_cyc !== 6)   $display("FAIL t2_read_cycles: got %0d required 6", rd_cyc);   else n_pass++;
        n_chk++; if (rv_cnt !== 4)   $display("FAIL t2_rd_valid_count: got %0d required 4", rv_cnt); else n_pass++;
        n_chk++; if (done_cnt !== 1) $display("FAIL t2_done_pulses: got %0d required 1", done_cnt); else n_pass++;
    endtask

    task automatic test_write_gaps();
        int done_cnt, both, k, next_ok;
        logic [39:0] exp;
        done_cnt = 0; both = 0; k = 0; next_ok = 0;
        for (int w = 0; w < 3; w++) exp_wr_q.push_back({8'(REG_START + w), 32'(w + 1)});
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            b2.cmd_start = (i == 0); b2.cmd_write = 1'b1; b2.cmd_addr = 8'(REG_START); b2.cmd_count = 8'd3;
            b2.wr_valid = (k < 3) && (i >= next_ok); b2.wr_data = 32'(k + 1);
            #1;
            if (b2.avm_read && b2.avm_write) both++;
            if (b2.avm_write && !b2.avm_waitrequest) begin
                n_chk++;
                if (exp_wr_q.size() == 0) $display("FAIL t3_extra_wr: addr %0d data %0d", b2.avm_addr, b2.avm_writedata);
                else begin
                    exp = exp_wr_q.pop_front();
                    if ({b2.avm_addr, b2.avm_writedata} !== exp || b2.avm_byte_en !== 4'hF)
                        $display("FAIL t3_write: got addr %0d data %0d be %h required addr %0d data %0d be f",
                                 b2.avm_addr, b2.avm_writedata, b2.avm_byte_en, exp[39:32], exp[31:0]);
                    else n_pass++;
                end
            end
            if (b2.wr_valid && b2.wr_ready) begin
                k++;
                next_ok = (k == 1) ? i + 4 : i + 1;
            end
            done_cnt += int'(b2.cmd_done);
        end
        b2.wr_valid = 1'b0; b2.cmd_write = 1'b0;
        n_chk++; if (done_cnt !== 1) $display("FAIL t3_done_pulses: got %0d required 1", done_cnt); else n_pass++;
        n_chk++; if (both !== 0)     $display("FAIL t3_rd_and_wr: got %0d cycles required 0", both); else n_pass++;
        n_chk++; if (exp_wr_q.size() !== 0) $display("FAIL t3_missing_wr: %0d left required 0", exp_wr_q.size()); else n_pass++;
    endtask

    task automatic test_zero_count();
        int done_cnt, done_at, cs_cnt, busy_cnt;
        done_cnt = 0; done_at = -1; cs_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b2.cmd_start = (i == 0); b2.cmd_write = 1'b0; b2.cmd_addr = 8'd5; b2.cmd_count = 8'd0;
            #1;
            cs_cnt   += int'(b2.avm_cs);
            busy_cnt += int'(b2.cmd_busy);
            if (b2.cmd_done) begin done_cnt++; done_at = i; end
        end
        n_chk++; if (done_cnt !== 1) $display("FAIL t4_done_pulses: got %0d required 1", done_cnt); else n_pass++;
        n_chk++; if (done_at !== 1)  $display("FAIL t4_done_cycle: got %0d required 1", done_at);   else n_pass++;
        n_chk++; if (cs_cnt !== 0)   $display("FAIL t4_cs_cycles: got %0d required 0", cs_cnt);    else n_pass++;
        n_chk++; if (busy_cnt !== 0) $display("FAIL t4_busy_cycles: got %0d required 0", busy_cnt); else n_pass++;
    endtask

    task automatic test_wrap_ignored_start();
        int rd_cnt, wr_seen, done_cnt;
        logic [7:0]  ea;
        logic [31:0] exp;
        rd_cnt = 0; wr_seen = 0; done_cnt = 0;
        exp_ad_q.push_back(8'd254); exp_ad_q.push_back(8'd255); exp_ad_q.push_back(8'd0);
        exp_rd_q.push_back(32'd354); exp_rd_q.push_back(32'd355); exp_rd_q.push_back(32'd100);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            b2.cmd_start = (i == 0 || i == 2); b2.cmd_write = (i == 2);
            b2.cmd_addr  = (i == 2) ? 8'd10 : 8'd254; b2.cmd_count = (i == 2) ? 8'd5 : 8'd3;
            #1;
            if (b2.avm_write) wr_seen++;
            if (b2.avm_read && !b2.avm_waitrequest) begin
                rd_cnt++;
                n_chk++;
                if (exp_ad_q.size() == 0) $display("FAIL t5_extra_read: addr %0d", b2.avm_addr);
                else begin
                    ea = exp_ad_q.pop_front();
                    if (b2.avm_addr !== ea) $display("FAIL t5_addr: got %0d required %0d", b2.avm_addr, ea);
                    else n_pass++;
                end
            end
            if (b2.rd_valid) begin
                n_chk++;
                if (exp_rd_q.size() == 0) $display("FAIL t5_extra_rd: got data %0d", b2.rd_data);
                else begin
                    exp = exp_rd_q.pop_front();
                    if (b2.rd_data !== exp) $display("FAIL t5_rd_data: got %0d required %0d", b2.rd_data, exp);
                    else n_pass++;
                end
            end
            done_cnt += int'(b2.cmd_done);
        end
        b2.cmd_write = 1'b0;
        n_chk++; if (rd_cnt !== 3)   $display("FAIL t5_reads: got %0d required 3", rd_cnt);         else n_pass++;
        n_chk++; if (wr_seen !== 0)  $display("FAIL t5_writes: got %0d required 0", wr_seen);       else n_pass++;
        n_chk++; if (done_cnt !== 1) $display("FAIL t5_done_pulses: got %0d required 1", done_cnt); else n_pass++;
        n_chk++; if (exp_rd_q.size() !== 0) $display("FAIL t5_missing_rd: %0d left required 0", exp_rd_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        int stray, done_cnt;
        logic [31:0] exp;
        stray = 0; done_cnt = 0;
        exp_rd_q.push_back(32'd160);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b2.cmd_start = (i == 0); b2.cmd_write = 1'b0; b2.cmd_addr = 8'd60; b2.cmd_count = 8'd4;
            #1;
            if (i == 5) begin
                n_chk++;
                if (!(b2.cmd_busy && !b2.avm_read)) $display("FAIL t6_in_drain: busy %0d read %0d required 1 0", b2.cmd_busy, b2.avm_read);
                else n_pass++;
                rst = 1'b1;
                #1;
                n_chk++;
                if ({b2.cmd_busy, b2.cmd_done, b2.wr_ready, b2.rd_data, b2.rd_valid, b2.avm_cs, b2.avm_read,
                     b2.avm_write, b2.avm_byte_en, b2.avm_addr, b2.avm_writedata} !== '0)
                    $display("FAIL t6_reset_outputs: busy %0d rd_valid %0d rd_data %0d cs %0d, required all 0",
                             b2.cmd_busy, b2.rd_valid, b2.rd_data, b2.avm_cs);
                else n_pass++;
            end else if (b2.rd_valid) begin
                n_chk++;
                if (exp_rd_q.size() == 0) $display("FAIL t6_extra_rd: got data %0d", b2.rd_data);
                else begin
                    exp = exp_rd_q.pop_front();
                    if (b2.rd_data !== exp) $display("FAIL t6_rd_data: got %0d required %0d", b2.rd_data, exp);
                    else n_pass++;
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
        b2.cmd_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            stray += int'(b2.rd_valid) + int'(b2.cmd_done) + int'(b2.avm_cs);
        end
        n_chk++; if (stray !== 0) $display("FAIL t6_after_reset_activity: got %0d required 0", stray); else n_pass++;
        n_chk++; if (exp_rd_q.size() !== 0) $display("FAIL t6_first_word: %0d left required 0", exp_rd_q.size()); else n_pass++;

        exp_rd_q.push_back(32'd170); exp_rd_q.push_back(32'd171);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            b2.cmd_start = (i == 0); b2.cmd_addr = 8'd70; b2.cmd_count = 8'd2;
            #1;
            if (b2.rd_valid) begin
                n_chk++;
                if (exp_rd_q.size() == 0) $display("FAIL t6_next_extra_rd: got data %0d", b2.rd_data);
                else begin
                    exp = exp_rd_q.pop_front();
                    if (b2.rd_data !== exp) $display("FAIL t6_next_rd_data: got %0d required %0d", b2.rd_data, exp);
                    else n_pass++;
                end
            end
            done_cnt += int'(b2.cmd_done);
        end
        n_chk++; if (done_cnt !== 1) $display("FAIL t6_next_done: got %0d required 1", done_cnt); else n_pass++;
        n_chk++; if (exp_rd_q.size() !== 0) $display("FAIL t6_next_missing_rd: %0d left required 0", exp_rd_q.size()); else n_pass++;
    endtask

    initial begin
        b0.cmd_start = 1'b0; b0.cmd_write = 1'b0; b0.cmd_addr = '0; b0.cmd_count = '0;
        b0.wr_data = '0; b0.wr_valid = 1'b0; b0.avm_waitrequest = 1'b0;
        b2.cmd_start = 1'b0; b2.cmd_write = 1'b0; b2.cmd_addr = '0; b2.cmd_count = '0;
        b2.wr_data = '0; b2.wr_valid = 1'b0; b2.avm_waitrequest = 1'b0;
        test_reset();
        test_read_zero_wait();
        test_read_stall();
        test_write_gaps();
        test_zero_count();
        test_wrap_ignored_start();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000, required finish");
        $fatal(1);
    end
endmodule

// File: doc/avalon_mm_seq_master.md
Name: avalon_mm_seq_master

Overview:
- Avalon-MM master (initiator) that drives the word-addressed Avalon-MM slave register file holding the G, planet count, start/done and per-body mass/radius/position/velocity/acceleration words.
- A local command port requests one block transfer: read or write of COUNT consecutive words starting at ADDR.
- Read words are returned on a valid-only stream. Write words are pulled from a valid/ready stream.
- Used by the host-side sequencer to load body state, set the start bit, poll the done bit and read back positions, without CPU involvement.

Parameters:
- ADDR_W, 8, Avalon word-address width.
- DATA_W, 32, Avalon data width. BYTE_EN is always all-ones, with width DATA_W/8.
- CNT_W, 8, width of the transfer count.
- READ_LATENCY, 0, fixed cycles from read acceptance to valid AVM_READDATA (0 = combinational slave); legal range 0..4.

Ports:
- CLK  in  1  system clock (50 MHz)
- RESET  in  1  asynchronous, active-high reset
- CMD_START  in  1  one-cycle request; sampled only in IDLE
- CMD_WRITE  in  1  1 = write block, 0 = read block; sampled with CMD_START
- CMD_ADDR  in  ADDR_W  first word address
- CMD_COUNT  in  CNT_W  number of words; 0 is legal
- CMD_BUSY  out  1  high from the cycle after an accepted start until the DONE pulse
- CMD_DONE  out  1  one-cycle completion pulse
- WR_DATA  in  DATA_W  write stream data
- WR_VALID  in  1  write stream valid
- WR_READY  out  1  write stream ready
- RD_DATA  out  DATA_W  read stream data (registered)
- RD_VALID  out  1  read stream valid, one cycle per word; no backpressure
- AVM_CS  out  1  chip select; high whenever AVM_READ or AVM_WRITE is high
- AVM_READ  out  1  read request
- AVM_WRITE  out  1  write request
- AVM_BYTE_EN  out  DATA_W/8  constant all-ones while requesting, 0 otherwise
- AVM_ADDR  out  ADDR_W  word address
- AVM_WRITEDATA  out  DATA_W  write data
- AVM_READDATA  in  DATA_W  slave read data
- AVM_WAITREQUEST  in  1  slave stall; tie to 0 for a zero-wait slave

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0, latency pipeline cleared.
  - Reset asserted mid-transfer aborts immediately.
  - In-flight read data is discarded and no DONE pulse is produced.
- States: IDLE, RD_REQ, RD_DRAIN, WR_FETCH, WR_REQ, FINISH.
- IDLE:
  - On CMD_START, latch ADDR, COUNT and WRITE.
  - COUNT = 0 goes to FINISH with no bus traffic.
  - Otherwise go to RD_REQ if WRITE = 0, or WR_FETCH if WRITE = 1.
  - CMD_START in any other state is ignored.
- Request acceptance: a request is accepted on a cycle where AVM_READ or AVM_WRITE is high and AVM_WAITREQUEST is low.
  - While stalled, AVM_ADDR, AVM_WRITEDATA and the request strobes are held stable.
- RD_REQ:
  - AVM_READ stays asserted back-to-back.
  - Address increments by 1 and issued count by 1 per acceptance.
  - After the last acceptance, deassert AVM_READ on the next cycle and go to RD_DRAIN.
- Read data capture:
  - A READ_LATENCY-deep valid shift register tags accepted reads.
  - AVM_READDATA is sampled READ_LATENCY cycles after acceptance (for 0, in the acceptance cycle).
  - RD_DATA/RD_VALID update on the following edge.
- RD_DRAIN: wait until all COUNT words have been captured, then go to FINISH.
- WR_FETCH / WR_REQ:
  - WR_READY = 1 only in WR_FETCH.
  - WR_VALID & WR_READY loads the holding register, then move to WR_REQ.
  - In WR_REQ, AVM_WRITE = 1 until accepted; then increment address, decrement remaining count, and go to WR_FETCH, or to FINISH after the last word.
  - Peak throughput: 1 word per 2 cycles.
- FINISH: CMD_DONE = 1 for exactly one cycle, CMD_BUSY = 0, then return to IDLE.
- Address arithmetic is modulo 2^ADDR_W, so a block wraps from 255 to 0 at the default width.
- Count arithmetic uses CNT_W bits; the maximum block is 2^CNT_W - 1 words.
- The block never asserts AVM_READ and AVM_WRITE in the same cycle.

Decomposition:
- Shared package gravsim_avm_pkg holds:
  - the state enum `avm_state_t`;
  - the register offsets: G = 0, NUM = 1, START = 2, DONE = 3, and MASS/RAD/POS_X/POS_Y/POS_Z/VEL_X/VEL_Y/VEL_Z/ACC_X/ACC_Y/ACC_Z bases;
  - MAX_BODIES = 10.
- One sub-module: avm_rd_latency_pipe, the parameterised valid shift register that produces the capture strobe.

Test Plan:
1. Read, zero-wait slave: READ_LATENCY = 0, ADDR = 23, COUNT = 4, slave returns its address+100 -> AVM_READ high 4 consecutive cycles with addresses 23..26; RD_VALID returns 123, 124, 125, 126 in order; CMD_DONE pulses once; BUSY lasts 5 cycles.
2. Read, with stalls: READ_LATENCY = 2, AVM_WAITREQUEST high on cycles 2 and 3 -> address held during the stall; exactly COUNT RD_VALID pulses, each 3 cycles after its acceptance.
3. Write with gaps: ADDR = 2, COUNT = 3, stream data 0x1, 0x2, 0x3 with a 2-cycle WR_VALID gap -> slave sees writes 0x1, 0x2, 0x3 at addresses 2, 3, 4 with BYTE_EN = 4'hF; one DONE pulse.
4. Zero count: COUNT = 0 -> CMD_DONE pulses 1 cycle after start; AVM_CS is never asserted.
5. Wrap and ignored start: ADDR = 254, COUNT = 3 read -> addresses 254, 255, 0; a second CMD_START issued while busy is ignored.
6. Reset mid-read: RESET pulse during RD_DRAIN -> all outputs 0 immediately, no DONE pulse, no further RD_VALID; the next command runs normally.
